// File: rtl/serial_tc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_tc_pkg
// Description : Shared types and constants for the serial two's-complement
//               link (transmit and receive sides).
// Revision    : 1.0 - initial release
// ============================================================================
package serial_tc_pkg;

    // Frame reception state
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Default number of bits per frame
    localparam int C_DEFAULT_WIDTH = 8;

    // Carry value loaded at reset and at every frame start
    localparam logic C_CARRY_RESET = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_negate_cell.sv
`default_nettype none
// ============================================================================
// Module      : serial_negate_cell
// Description : Bit-serial two's-complement cell. For each enabled bit b:
//               r = ~b ^ carry, carry' = ~b & carry. A restart forces the
//               carry to its reset value before the current bit is processed.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_negate_cell
    import serial_tc_pkg::*;
(
    input  logic Clock,
    input  logic reset_b,
    input  logic bit_in,
    input  logic enable,
    input  logic restart,
    output logic r
);

    logic r_carry;
    logic w_carry_eff;

    // A restart bit is always processed with a fresh carry
    assign w_carry_eff = restart ? C_CARRY_RESET : r_carry;
    assign r           = (~bit_in) ^ w_carry_eff;

    // Carry flop advances only on accepted bits
    always_ff @(posedge Clock) begin
        if (!reset_b) begin
            r_carry <= C_CARRY_RESET;
        end else if (enable) begin
            r_carry <= (~bit_in) & w_carry_eff;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_twos_comp_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_twos_comp_rx
// Description : Receive end of the serial two's-complement link. Deserialises
//               an LSB-first bitstream, optionally re-negating each frame,
//               and presents the word on a valid/ready output. Reception of
//               the next frame overlaps with the held output word.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_twos_comp_rx
    import serial_tc_pkg::*;
#(
    parameter int WIDTH  = C_DEFAULT_WIDTH,
    parameter bit NEGATE = 1'b1
) (
    input  logic             Clock,
    input  logic             reset_b,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int                CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    logic             w_accept;
    logic             w_restart;
    logic             w_neg_r;
    logic             w_r;
    logic             w_last;
    logic             w_take;
    logic [WIDTH-1:0] w_word;

    // In IDLE only a frame_start bit is accepted; in RECV every valid bit is
    assign w_accept  = bit_valid && (frame_start || (r_state == RECV));
    assign w_restart = bit_valid && frame_start;

    // A frame_start bit is always bit 0, so it can never be the last bit
    assign w_last = w_accept && !frame_start && (r_state == RECV) && (r_count == C_LAST);
    assign w_take = r_valid && out_ready;

    serial_negate_cell u_negate (
        .Clock   (Clock),
        .reset_b (reset_b),
        .bit_in  (serial_in),
        .enable  (w_accept),
        .restart (w_restart),
        .r       (w_neg_r)
    );

    assign w_r    = NEGATE ? w_neg_r : serial_in;
    // Word as it will stand after the current bit is shifted in
    assign w_word = {w_r, r_shift[WIDTH-1:1]};

    // Frame FSM, bit counter and shift register
    always_ff @(posedge Clock) begin
        if (!reset_b) begin
            r_state <= IDLE;
            r_count <= '0;
            r_shift <= '0;
        end else if (w_accept) begin
            r_shift <= w_word;
            if (frame_start) begin
                r_state <= RECV;
                r_count <= C_ONE;
            end else if (w_last) begin
                r_state <= IDLE;
                r_count <= '0;
            end else begin
                r_count <= r_count + C_ONE;
            end
        end
    end

    // Output register: load on completion when free, else flag the drop
    always_ff @(posedge Clock) begin
        if (!reset_b) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_last) begin
                if (!r_valid || w_take) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_take) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;
    assign busy      = (r_state == RECV);

endmodule
`default_nettype wire

// File: tb/tb_serial_twos_comp_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_twos_comp_rx
// Description : Directed, table-driven bench for serial_twos_comp_rx. Two
//               instances (NEGATE=1 and NEGATE=0) share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_twos_comp_rx;

    logic       Clock;
    logic       reset_b;
    logic       serial_in;
    logic       bit_valid;
    logic       frame_start;
    logic       out_ready;

    logic [7:0] data_out_n;
    logic       out_valid_n;
    logic       overrun_n;
    logic       busy_n;

    logic [7:0] data_out_p;
    logic       out_valid_p;
    logic       overrun_p;
    logic       busy_p;

    int n_vec;
    int n_err;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_neg;
    } vec_t;

    vec_t vecs [6];

    serial_twos_comp_rx #(.WIDTH(8), .NEGATE(1'b1)) dut_neg (
        .Clock       (Clock),
        .reset_b     (reset_b),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .data_out    (data_out_n),
        .out_valid   (out_valid_n),
        .out_ready   (out_ready),
        .overrun     (overrun_n),
        .busy        (busy_n)
    );

    serial_twos_comp_rx #(.WIDTH(8), .NEGATE(1'b0)) dut_plain (
        .Clock       (Clock),
        .reset_b     (reset_b),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .data_out    (data_out_p),
        .out_valid   (out_valid_p),
        .out_ready   (out_ready),
        .overrun     (overrun_p),
        .busy        (busy_p)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Send one bit; frame_start marks bit 0
    task automatic send_bit(input logic b, input logic fs);
        serial_in   = b;
        bit_valid   = 1'b1;
        frame_start = fs;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Send bits [lo..hi] of w LSB-first, optional random idle gaps before each
    task automatic send_bits(input logic [7:0] w, input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) begin
                    serial_in = $urandom_range(0, 1);
                    tick();
                end
            end
            send_bit(w[i], (i == 0));
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset_b     = 1'b0;
        serial_in   = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b0;

        vecs[0] = '{tx: 8'hFB, exp_neg: 8'h05};
        vecs[1] = '{tx: 8'h00, exp_neg: 8'h00};
        vecs[2] = '{tx: 8'h80, exp_neg: 8'h80};
        vecs[3] = '{tx: 8'hA5, exp_neg: 8'h5B};
        vecs[4] = '{tx: 8'h01, exp_neg: 8'hFF};
        vecs[5] = '{tx: 8'h7F, exp_neg: 8'h81};

        tick();
        tick();
        check("reset data_out",  data_out_n, 8'h00);
        check("reset out_valid", {7'd0, out_valid_n}, 8'h00);
        check("reset busy",      {7'd0, busy_n}, 8'h00);
        check("reset overrun",   {7'd0, overrun_n}, 8'h00);
        reset_b = 1'b1;
        tick();

        // Bits without frame_start while idle are ignored
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("idle ignore busy", {7'd0, busy_n}, 8'h00);

        // Table-driven frames, continuous bit_valid, consumer stalled
        for (int v = 0; v < 6; v++) begin
            send_bits(vecs[v].tx, 0, 0, 1'b0);
            check("busy after bit0", {7'd0, busy_n}, 8'h01);
            send_bits(vecs[v].tx, 1, 6, 1'b0);
            check("no valid before last", {7'd0, out_valid_n}, 8'h00);
            send_bits(vecs[v].tx, 7, 7, 1'b0);
            check("vec data_out neg",   data_out_n, vecs[v].exp_neg);
            check("vec data_out plain", data_out_p, vecs[v].tx);
            check("vec out_valid",      {7'd0, out_valid_n}, 8'h01);
            check("vec busy low",       {7'd0, busy_n}, 8'h00);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("vec taken valid", {7'd0, out_valid_n}, 8'h00);
            check("vec held data",   data_out_n, vecs[v].exp_neg);
        end

        // Gapped frame with consumer always ready: one-cycle valid
        out_ready = 1'b1;
        send_bits(8'hFE, 0, 7, 1'b1);
        check("gap data_out",  data_out_n, 8'h02);
        check("gap out_valid", {7'd0, out_valid_n}, 8'h01);
        tick();
        check("gap valid one cycle", {7'd0, out_valid_n}, 8'h00);
        out_ready = 1'b0;

        // Back-to-back frames with a stalled consumer: second is dropped
        send_bits(8'hFF, 0, 7, 1'b0);
        check("b2b first data",   data_out_n, 8'h01);
        check("b2b first valid",  {7'd0, out_valid_n}, 8'h01);
        check("b2b no overrun",   {7'd0, overrun_n}, 8'h00);
        send_bits(8'hFE, 0, 7, 1'b0);
        check("b2b overrun pulse", {7'd0, overrun_n}, 8'h01);
        check("b2b data kept",     data_out_n, 8'h01);
        check("b2b valid kept",    {7'd0, out_valid_n}, 8'h01);
        tick();
        check("b2b overrun ends",  {7'd0, overrun_n}, 8'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("b2b valid drops",   {7'd0, out_valid_n}, 8'h00);
        check("b2b data after",    data_out_n, 8'h01);

        // Partial frame aborted by a new frame_start
        send_bits(8'h3C, 0, 3, 1'b0);
        send_bits(8'hF0, 0, 6, 1'b0);
        check("restart not early", {7'd0, out_valid_n}, 8'h00);
        check("restart busy",      {7'd0, busy_n}, 8'h01);
        send_bits(8'hF0, 7, 7, 1'b0);
        check("restart data",      data_out_n, 8'h10);
        check("restart valid",     {7'd0, out_valid_n}, 8'h01);

        // Reset while out_valid is held
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        check("rst held data",  data_out_n, 8'h00);
        check("rst held valid", {7'd0, out_valid_n}, 8'h00);
        send_bits(8'h01, 0, 7, 1'b0);
        check("rst held next", data_out_n, 8'hFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-frame discards the partial frame
        send_bits(8'h55, 0, 2, 1'b0);
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        check("rst mid busy",  {7'd0, busy_n}, 8'h00);
        check("rst mid data",  data_out_n, 8'h00);
        check("rst mid valid", {7'd0, out_valid_n}, 8'h00);
        send_bits(8'h01, 0, 7, 1'b0);
        check("rst mid next data",  data_out_n, 8'hFF);
        check("rst mid next valid", {7'd0, out_valid_n}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_twos_comp_rx.md
Name: serial_twos_comp_rx

Overview:
Receive end of the serial two's-complement link. Takes an LSB-first serial bitstream, one bit per qualified clock, and re-applies serial two's complementation (NEGATE=1) to recover the original operand. Assembles WIDTH bits into a parallel word and presents it on a valid/ready output.
Shift register and output register are separate, so reception of the next frame continues while the previous word waits to be taken.

Parameters:
WIDTH, 8, bits per frame (>=2)
NEGATE, 1, 1 = serially two's-complement each frame; 0 = plain deserialise

Ports:
Clock  input  1  single clock; all state updates on posedge
reset_b  input  1  synchronous reset, active-low, sampled on posedge Clock
serial_in  input  1  serial data bit, LSB of frame first
bit_valid  input  1  serial_in is a valid bit this cycle
frame_start  input  1  qualified by bit_valid; marks bit 0 of a frame
data_out  output  WIDTH  assembled (and optionally negated) word
out_valid  output  1  data_out holds an untaken word
out_ready  input  1  consumer accepts data_out when out_valid=1
overrun  output  1  one-cycle pulse: completed frame dropped
busy  output  1  frame reception in progress (state RECV)

Behaviour:
- Reset (reset_b=0 at posedge): state=IDLE, bit count=0, carry=1, shift register=0, data_out=0, out_valid=0, overrun=0, busy=0. Reset mid-frame discards the partial frame; reset with out_valid=1 discards the held word.
- Serial negate cell, per accepted bit b: r = (~b) XOR carry; next carry = (~b) AND carry. Carry is set to 1 on every accepted frame_start bit, before that bit is processed. When NEGATE=0, r = b and carry is ignored.
- Shift register shifts right, inserting r at MSB. After WIDTH accepted bits, bit 0 of the frame sits in the LSB.
- State machine:
  - IDLE: stays until bit_valid&frame_start. That bit is accepted as bit 0, count=1, go to RECV. A bit_valid without frame_start in IDLE is ignored.
  - RECV: each bit_valid accepts one bit and increments count.
  - bit_valid=0 cycles are gaps: no state change.
  - bit_valid&frame_start in RECV aborts the partial frame and restarts at bit 0, with carry=1 and count=1.
  - On acceptance of bit WIDTH-1: frame complete, count=0, return to IDLE.
- Completion transfer, on the edge that accepts the last bit:
  - If out_valid=0, or out_valid&out_ready in the same cycle: data_out <= completed word, out_valid=1 from the next cycle. Latency is 1 clock from last-bit edge to out_valid visible.
  - Else: the new word is dropped, data_out and out_valid are unchanged, and overrun pulses high for exactly one cycle.
- Handshake: out_valid&out_ready with no completion clears out_valid on the next edge. data_out holds its value after being taken (not cleared). data_out is stable while out_valid=1 and out_ready=0.
- busy = (state==RECV). A WIDTH=1 frame is not supported.
- A frame_start in the same cycle as a last-bit acceptance is not possible: the last bit is a normal bit, and frame_start on it means a restart.

Decomposition:
- Shared package serial_tc_pkg: state enum (IDLE, RECV), default WIDTH constant 8, carry reset value constant 1. The existing transmitter uses the same package.
- One sub-module: serial_negate_cell. It holds the carry flop, with inputs bit, enable, restart, and output r. It is reused by the transmit side.
- Counter, shift register, output register and FSM stay in the top module.

Test Plan:
- NEGATE=1, send 8'hFB LSB-first with bit_valid continuous, frame_start on bit 0 -> data_out=8'h05, out_valid=1 one cycle after the 8th bit, busy low after.
- Send 8'h00 and 8'h80 frames -> data_out=8'h00 (carry ripples through) and 8'h80. With NEGATE=0, 8'hA5 -> 8'hA5.
- Frame 8'hFE with random bit_valid gaps, out_ready=1 -> data_out=8'h02, out_valid for exactly one cycle.
- Two back-to-back frames (8'hFF, 8'hFE), out_ready=0 -> data_out stays 8'h01, overrun one-cycle pulse at second completion. Then raise out_ready -> out_valid drops.
- 4 bits of a frame, then frame_start with a new full frame 8'hF0 -> data_out=8'h10; the partial frame leaves no trace.
- reset_b=0 for one cycle mid-frame and once with out_valid=1 -> all outputs 0, the next clean frame 8'h01 yields 8'hFF.
